// File: rtl/muldiv_hilo_controller_pkg.sv
// Shared definitions for the mul/div HI/LO controller: FSM states, ALU op codes, constants.
// Optional feature macro used by this block: MULDIV_EARLY_OUT_EN.
package muldiv_hilo_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Execute-stage ALU op encodings; only the four mul/div codes act here.
  localparam logic [4:0] ALU_OP_ADD  = 5'h00;
  localparam logic [4:0] ALU_OP_SUB  = 5'h01;
  localparam logic [4:0] ALU_OP_AND  = 5'h02;
  localparam logic [4:0] ALU_OP_OR   = 5'h03;
  localparam logic [4:0] ALU_OP_MUL  = 5'h10;
  localparam logic [4:0] ALU_OP_MULU = 5'h11;
  localparam logic [4:0] ALU_OP_DIV  = 5'h12;
  localparam logic [4:0] ALU_OP_DIVU = 5'h13;

  // LO value after a divide by zero; truncated to the configured data width.
  localparam logic [63:0] DIV_BY_ZERO_LO = '1;

endpackage

// File: rtl/muldiv_hilo_controller_if.sv
// Execute-stage <-> mul/div controller bundle: issue strobe, flush, status and HI/LO.
interface muldiv_hilo_controller_if
  import muldiv_hilo_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5
);
  // Handshake: start is a single-cycle issue strobe with no ready; it is taken only
  // when the controller is idle and flush is low, otherwise dropped. The issuer holds
  // off while busy is high, and done pulses for one cycle when HI/LO are written.
  logic                    start;
  logic [ALU_OP_WIDTH-1:0] op;
  logic [DATA_WIDTH-1:0]   rs;
  logic [DATA_WIDTH-1:0]   rt;
  logic                    flush;
  logic                    busy;
  logic                    done;
  logic [DATA_WIDTH-1:0]   hi;
  logic [DATA_WIDTH-1:0]   lo;
  state_t                  dbg_state;

  modport master (
    output start, op, rs, rt, flush,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, rs, rt, flush,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_hilo_controller_divider_core.sv
// Unsigned restoring divider: load latches operands, each step retires one quotient bit.
module muldiv_divider_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] dsr_q;
  logic [DATA_WIDTH:0]   trial;

  // Top bit of the trial difference is the borrow: set means the subtraction is undone.
  assign trial = {rem_q, quo_q[DATA_WIDTH-1]} - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      if (!trial[DATA_WIDTH]) begin
        rem_q <= trial[DATA_WIDTH-1:0];
        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
        quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/muldiv_hilo_controller.sv
// Multi-cycle MUL/MULU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to skip division iterations when |rs| < |rt| at issue.
module muldiv_hilo_controller
  import muldiv_hilo_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 5,
  parameter int MUL_LATENCY  = 3
) (
  input logic                     clk,
  input logic                     rst,
  muldiv_hilo_controller_if.slave bus
);
  localparam int CNT_MAX = (DATA_WIDTH > MUL_LATENCY) ? DATA_WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                  state;
  logic                    busy_q, done_q;
  logic [DATA_WIDTH-1:0]   hi_q, lo_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]        cnt;
  logic                    signed_q, neg_quo_q, neg_rem_q, skip_q, dbz_q;

  logic                    is_mul_op, is_div_op, op_signed, issue, early;
  logic                    rs_neg, rt_neg;
  logic [DATA_WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*DATA_WIDTH-1:0] prod_s, prod_u;
  logic [DATA_WIDTH-1:0]   core_quo, core_rem, fix_lo, fix_hi;

  always_comb begin
    is_mul_op = (bus.op == ALU_OP_WIDTH'(ALU_OP_MUL)) || (bus.op == ALU_OP_WIDTH'(ALU_OP_MULU));
    is_div_op = (bus.op == ALU_OP_WIDTH'(ALU_OP_DIV)) || (bus.op == ALU_OP_WIDTH'(ALU_OP_DIVU));
    op_signed = (bus.op == ALU_OP_WIDTH'(ALU_OP_MUL)) || (bus.op == ALU_OP_WIDTH'(ALU_OP_DIV));
    issue     = (state == ST_IDLE) && bus.start && !bus.flush && (is_mul_op || is_div_op);
    rs_neg    = op_signed && bus.rs[DATA_WIDTH-1];
    rt_neg    = op_signed && bus.rt[DATA_WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs : bus.rs;
    rt_mag    = rt_neg ? -bus.rt : bus.rt;
`ifdef MULDIV_EARLY_OUT_EN
    early     = rs_mag < rt_mag;
`else
    early     = 1'b0;
`endif
  end

  muldiv_divider_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (issue && is_div_op),
    .step      ((state == ST_DIV) && !skip_q),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_comb begin
    prod_s = $signed({{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q})
           * $signed({{DATA_WIDTH{b_q[DATA_WIDTH-1]}}, b_q});
    prod_u = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
    fix_lo = neg_quo_q ? -core_quo : core_quo;
    fix_hi = neg_rem_q ? -core_rem : core_rem;
    // Skipped divisions (zero divisor or early out) return the raw dividend in HI.
    if (skip_q) begin
      fix_lo = dbz_q ? DATA_WIDTH'(DIV_BY_ZERO_LO) : '0;
      fix_hi = a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      skip_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy_q <= 1'b0;
            if (issue) begin
              a_q       <= bus.rs;
              b_q       <= bus.rt;
              signed_q  <= op_signed;
              neg_quo_q <= rs_neg ^ rt_neg;
              neg_rem_q <= rs_neg;
              dbz_q     <= (bus.rt == '0);
              skip_q    <= (bus.rt == '0) || early;
              state     <= is_mul_op ? ST_MUL : ST_DIV;
              cnt       <= is_mul_op ? CNT_W'(MUL_LATENCY - 1) : CNT_W'(DATA_WIDTH - 1);
            end
          end
          ST_MUL: begin
            if (cnt == '0) begin
              {hi_q, lo_q} <= signed_q ? prod_s : prod_u;
              done_q       <= 1'b1;
              busy_q       <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              cnt    <= cnt - CNT_W'(1);
              busy_q <= 1'b1;
            end
          end
          ST_DIV: begin
            busy_q <= 1'b1;
            if (skip_q || (cnt == '0)) state <= ST_FIX;
            else                       cnt   <= cnt - CNT_W'(1);
          end
          ST_FIX: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_hilo_controller.sv
// Self-checking bench for muldiv_hilo_controller: directed cases plus randomized ops
// compared against an arithmetic reference model of HI/LO and latency.
module tb_muldiv_hilo_controller;
  import muldiv_hilo_controller_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0]   cur_hi = '0;
  logic [W-1:0]   cur_lo = '0;
  logic [2*W-1:0] exp_q[$];

  muldiv_hilo_controller_if #(.DATA_WIDTH(W), .ALU_OP_WIDTH(5)) bus ();

  muldiv_hilo_controller #(
    .DATA_WIDTH   (W),
    .ALU_OP_WIDTH (5),
    .MUL_LATENCY  (MUL_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: plain arithmetic on the architectural rules
  task automatic model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el, output int lat);
    longint    sa, sb, ma, mb;
    logic [63:0] p;
    bit        early_en;
`ifdef MULDIV_EARLY_OUT_EN
    early_en = 1'b1;
`else
    early_en = 1'b0;
`endif
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    lat = W + 1;
    eh = '0;
    el = '0;
    if (o == ALU_OP_MUL) begin
      p = 64'(sa * sb);
      {eh, el} = p;
      lat = MUL_LAT;
    end else if (o == ALU_OP_MULU) begin
      p = {32'h0, a} * {32'h0, b};
      {eh, el} = p;
      lat = MUL_LAT;
    end else begin
      ma = (o == ALU_OP_DIV && sa < 0) ? -sa : longint'({32'h0, a});
      mb = (o == ALU_OP_DIV && sb < 0) ? -sb : longint'({32'h0, b});
      if (b == '0) begin
        el = '1; eh = a; lat = 2;
      end else if (early_en && ma < mb) begin
        el = '0; eh = a; lat = 2;
      end else if (o == ALU_OP_DIV) begin
        el = W'((sa / sb));
        eh = W'((sa % sb));
      end else begin
        el = a / b;
        eh = a % b;
      end
    end
  endtask

  // driver: issue one op and follow it to done, checking busy/done/HI/LO each cycle
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    logic [W-1:0] eh, el;
    logic [2*W-1:0] e;
    int lat, inj_k;
    model(o, a, b, eh, el, lat);
    exp_q.push_back({eh, el});
    inj_k = (inject && lat > 1) ? $urandom_range(1, lat - 1) : 0;
    bus.start = 1'b1; bus.op = o; bus.rs = a; bus.rt = b;
    tick();
    bus.start = 1'b0; bus.op = ALU_OP_ADD; bus.rs = $urandom; bus.rt = $urandom;
    check("issue_busy", bus.busy, 0);
    check("issue_done", bus.done, 0);
    for (int k = 1; k <= lat; k++) begin
      if (k == inj_k) begin
        bus.start = 1'b1; bus.op = ALU_OP_MULU; bus.rs = $urandom; bus.rt = $urandom;
      end
      tick();
      bus.start = 1'b0;
      if (k < lat) begin
        check("busy_wait", bus.busy, 1);
        check("done_early", bus.done, 0);
        check("hi_hold", bus.hi, cur_hi);
        check("lo_hold", bus.lo, cur_lo);
      end else begin
        check("done_at_lat", bus.done, 1);
        check("busy_at_done", bus.busy, 0);
        e = exp_q.pop_front();
        check("hi_result", bus.hi, e[2*W-1:W]);
        check("lo_result", bus.lo, e[W-1:0]);
        cur_hi = e[2*W-1:W];
        cur_lo = e[W-1:0];
      end
    end
    tick();
    check("done_pulse_end", bus.done, 0);
    check("busy_after", bus.busy, 0);
  endtask

  task automatic rand_operands(output logic [W-1:0] a, output logic [W-1:0] b);
    case ($urandom_range(0, 5))
      0: begin a = $urandom; b = $urandom; end
      1: begin a = $urandom; b = '0; end
      2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
      3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      4: begin a = $urandom; b = 32'(-$urandom_range(1, 9)); end
      default: begin a = $urandom_range(0, 50); b = $urandom_range(51, 1000); end
    endcase
  endtask

  initial begin
    logic [4:0] ops[4];
    logic [W-1:0] a, b;
    int dones;
    ops[0] = ALU_OP_MUL; ops[1] = ALU_OP_MULU; ops[2] = ALU_OP_DIV; ops[3] = ALU_OP_DIVU;
    bus.start = 1'b0; bus.op = ALU_OP_ADD; bus.rs = '0; bus.rt = '0; bus.flush = 1'b0;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b0;
    tick();

    // directed arithmetic cases
    run_op(ALU_OP_MUL,  32'hFFFF_FFFD, 32'd7, 1'b0);
    run_op(ALU_OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(ALU_OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(ALU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(ALU_OP_DIVU, 32'd100, 32'd0, 1'b0);
    run_op(ALU_OP_DIVU, 32'd5, 32'd9, 1'b0);

    // start while busy does not disturb the result
    run_op(ALU_OP_DIVU, 32'd100, 32'd7, 1'b1);
    check("divu_100_7_lo", cur_lo, 32'd14);
    check("divu_100_7_hi", cur_hi, 32'd2);

    // flush mid-division
    bus.start = 1'b1; bus.op = ALU_OP_DIV; bus.rs = 32'd100; bus.rt = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_done", bus.done, 0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done) dones++;
    end
    check("flush_no_done", 64'(dones), 0);
    check("flush_hi_keep", bus.hi, cur_hi);
    check("flush_lo_keep", bus.lo, cur_lo);

    // start in the same cycle as flush, then a non-mul/div op: both ignored
    bus.start = 1'b1; bus.op = ALU_OP_DIVU; bus.rs = 32'd9; bus.rt = 32'd3; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.op = ALU_OP_SUB;
    tick();
    bus.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("ignored_starts", 64'(dones), 0);
    check("ignored_lo_keep", bus.lo, cur_lo);

    // reset in the middle of a division
    bus.start = 1'b1; bus.op = ALU_OP_DIV; bus.rs = 32'd1000; bus.rt = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_hi", bus.hi, 0);
    check("midrst_lo", bus.lo, 0);
    cur_hi = '0; cur_lo = '0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("midrst_quiet", 64'(dones), 0);

    // randomized ops against the model
    for (int n = 0; n < 40; n++) begin
      rand_operands(a, b);
      run_op(ops[$urandom_range(0, 3)], a, b, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
